// File: rtl/cpu_types_pkg.sv
// Shared CPU/memory types. Only the RAM handshake state is needed by the arbiter.
package cpu_types_pkg;
  typedef enum logic [1:0] {
    FREE   = 2'd0,
    BUSY   = 2'd1,
    ACCESS = 2'd2,
    ERROR  = 2'd3
  } ramstate_t;
endpackage

// File: rtl/ram_rr_arbiter_pkg.sv
// Types and helpers local to the RAM round-robin arbiter.
package ram_rr_arbiter_pkg;
  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } arb_state_t;

  localparam int STAT_W = 16;

  // Saturating increment for the optional statistics counters.
  function automatic logic [STAT_W-1:0] sat_inc16(input logic [STAT_W-1:0] v);
    return (v == {STAT_W{1'b1}}) ? v : v + 16'd1;
  endfunction
endpackage

// File: rtl/ram_rr_arbiter_if.sv
// Requester and RAM-side bundle for ram_rr_arbiter.
// slave = arbiter view, master = environment (caches + RAM model) view.
interface ram_rr_arbiter_if #(
  parameter int NREQ   = 4,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  import cpu_types_pkg::*;

  logic [NREQ-1:0]        req_ren;
  logic [NREQ-1:0]        req_wen;
  logic [NREQ-1:0]        req_lock;
  logic [NREQ*ADDR_W-1:0] req_addr;
  logic [NREQ*DATA_W-1:0] req_store;
  logic [NREQ-1:0]        req_wait;
  logic [DATA_W-1:0]      req_load;
  logic                   grant_valid;
  logic [$clog2(NREQ)-1:0] grant_idx;
  logic                   ramREN;
  logic                   ramWEN;
  logic [ADDR_W-1:0]      ramaddr;
  logic [DATA_W-1:0]      ramstore;
  logic [DATA_W-1:0]      ramload;
  ramstate_t              ramstate;
  logic                   err_sticky;

  modport slave (
    input  req_ren, req_wen, req_lock, req_addr, req_store, ramload, ramstate,
    output req_wait, req_load, grant_valid, grant_idx,
           ramREN, ramWEN, ramaddr, ramstore, err_sticky
  );

  modport master (
    output req_ren, req_wen, req_lock, req_addr, req_store, ramload, ramstate,
    input  req_wait, req_load, grant_valid, grant_idx,
           ramREN, ramWEN, ramaddr, ramstore, err_sticky
  );
endinterface

// File: rtl/ram_rr_arbiter_rr_pick.sv
// Rotating-priority encoder: first set bit of req searching start, start+1, ...
// N must be a power of two so the index add wraps naturally.
module rr_pick #(
  parameter int N  = 4,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] start,
  output logic          found,
  output logic [IW-1:0] idx
);
  logic [IW-1:0] cand;

  // Scan from farthest to nearest offset so the nearest active index wins.
  always_comb begin
    found = 1'b0;
    idx   = start;
    cand  = '0;
    for (int k = N - 1; k >= 0; k--) begin
      cand = start + IW'(k);
      if (req[cand]) begin
        found = 1'b1;
        idx   = cand;
      end
    end
  end
endmodule

// File: rtl/ram_rr_arbiter.sv
// Round-robin arbiter sharing one RAM port between NREQ requesters.
// Locked bursts are capped at MAX_BURST beats per grant; one IDLE bubble
// separates consecutive grants. Define ARB_STATS_EN to add grant and
// max-wait statistics ports.
module ram_rr_arbiter
  import ram_rr_arbiter_pkg::*;
  import cpu_types_pkg::*;
#(
  parameter int NREQ      = 4,
  parameter int MAX_BURST = 2,
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32
) (
  input  logic CLK,
  input  logic nRST,
  ram_rr_arbiter_if.slave bus
`ifdef ARB_STATS_EN
  ,
  output logic [NREQ*16-1:0] stat_grants,
  output logic [15:0]        stat_maxwait
`endif
);
  localparam int IW = $clog2(NREQ);
  localparam int BW = $clog2(MAX_BURST + 1);

  arb_state_t      state;
  logic [IW-1:0]   rr_ptr;
  logic [IW-1:0]   gidx;
  logic [BW-1:0]   beat_cnt;
  logic            gvalid;
  logic            err_q;

  logic [NREQ-1:0] active;
  logic            pick_found;
  logic [IW-1:0]   pick_idx;
  logic            g_active;
  logic            beat_done;
  logic            more_beats;

  assign active     = bus.req_ren | bus.req_wen;
  assign g_active   = active[gidx];
  assign beat_done  = (bus.ramstate == ACCESS) || (bus.ramstate == ERROR);
  assign more_beats = bus.req_lock[gidx] && ((beat_cnt + BW'(1)) < BW'(MAX_BURST));

  rr_pick #(.N(NREQ), .IW(IW)) u_pick (
    .req   (active),
    .start (rr_ptr),
    .found (pick_found),
    .idx   (pick_idx)
  );

  assign bus.grant_valid = gvalid;
  assign bus.grant_idx   = gidx;
  assign bus.err_sticky  = err_q;
  assign bus.req_load    = bus.ramload;

  // RAM port follows the granted requester's live inputs; everything idle otherwise.
  always_comb begin
    bus.ramREN   = 1'b0;
    bus.ramWEN   = 1'b0;
    bus.ramaddr  = '0;
    bus.ramstore = '0;
    bus.req_wait = '1;
    if (state == GRANT) begin
      bus.ramWEN         = bus.req_wen[gidx];
      bus.ramREN         = bus.req_ren[gidx] & ~bus.req_wen[gidx];
      bus.ramaddr        = bus.req_addr[gidx*ADDR_W +: ADDR_W];
      bus.ramstore       = bus.req_store[gidx*DATA_W +: DATA_W];
      bus.req_wait[gidx] = ~beat_done;
    end
  end

  // Arbitration FSM: pick in IDLE, hold for a beat or a capped locked burst.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state    <= IDLE;
      rr_ptr   <= '0;
      gidx     <= '0;
      beat_cnt <= '0;
      gvalid   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (pick_found) begin
            state    <= GRANT;
            gidx     <= pick_idx;
            beat_cnt <= '0;
            gvalid   <= 1'b1;
          end
        end
        GRANT: begin
          if (!g_active) begin
            state  <= IDLE;
            gvalid <= 1'b0;
            rr_ptr <= gidx + IW'(1);
          end else if (beat_done) begin
            beat_cnt <= beat_cnt + BW'(1);
            if (bus.ramstate == ERROR) err_q <= 1'b1;
            if (!more_beats) begin
              state  <= IDLE;
              gvalid <= 1'b0;
              rr_ptr <= gidx + IW'(1);
            end
          end
        end
        default: begin
          state  <= IDLE;
          gvalid <= 1'b0;
        end
      endcase
    end
  end

`ifdef ARB_STATS_EN
  logic [NREQ-1:0][15:0] grants_q;
  logic [NREQ-1:0][15:0] wait_q;
  logic [15:0]           maxw_q;
  logic [15:0]           wait_max;

  // Longest current wait run across requesters, folded with the recorded max.
  always_comb begin
    wait_max = maxw_q;
    for (int i = 0; i < NREQ; i++)
      if (wait_q[i] > wait_max) wait_max = wait_q[i];
  end

  // Per-requester grant counts and wait-run lengths, all saturating.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      grants_q <= '0;
      wait_q   <= '0;
      maxw_q   <= '0;
    end else begin
      for (int i = 0; i < NREQ; i++) begin
        if (state == IDLE && pick_found && pick_idx == IW'(i))
          grants_q[i] <= sat_inc16(grants_q[i]);
        if (active[i] && !(gvalid && gidx == IW'(i)))
          wait_q[i] <= sat_inc16(wait_q[i]);
        else
          wait_q[i] <= '0;
      end
      maxw_q <= wait_max;
    end
  end

  assign stat_grants  = grants_q;
  assign stat_maxwait = maxw_q;
`endif
endmodule

// File: tb/tb_ram_rr_arbiter.sv
// Bench for ram_rr_arbiter: directed scenarios plus a randomized phase.
// A transaction-level model predicts every RAM beat into a scoreboard queue;
// a separate monitor pops and compares whenever the DUT completes a beat.
`timescale 1ns/1ps
module tb_ram_rr_arbiter;
  import cpu_types_pkg::*;

  localparam int NREQ = 4, MAX_BURST = 2, ADDR_W = 32, DATA_W = 32;

  logic CLK = 1'b0;
  logic nRST = 1'b0;
  always #5 CLK = ~CLK;

  ram_rr_arbiter_if #(.NREQ(NREQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus();
`ifdef ARB_STATS_EN
  logic [NREQ*16-1:0] stat_grants;
  logic [15:0]        stat_maxwait;
`endif

  ram_rr_arbiter #(.NREQ(NREQ), .MAX_BURST(MAX_BURST), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .CLK  (CLK),
    .nRST (nRST),
    .bus  (bus)
`ifdef ARB_STATS_EN
    ,
    .stat_grants  (stat_grants),
    .stat_maxwait (stat_maxwait)
`endif
  );

  typedef struct {
    int          idx;
    logic        wen;
    logic        ren;
    logic [31:0] addr;
    logic [31:0] store;
    logic [31:0] load;
  } beat_t;

  beat_t sb[$];
  int    cur_owner = -1;
  int    checks = 0;
  int    errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference model: one owner at a time, rotating start after each release.
  initial begin : model
    int owner, ptr, beats;
    owner = -1; ptr = 0; beats = 0;
    forever begin
      @(negedge CLK);
      if (!nRST) begin
        owner = -1; ptr = 0; beats = 0; cur_owner = -1;
        sb.delete();
      end else begin
        cur_owner = owner;
        if (owner < 0) begin
          for (int k = 0; k < NREQ; k++)
            if (owner < 0 && (bus.req_ren[(ptr + k) % NREQ] || bus.req_wen[(ptr + k) % NREQ]))
              owner = (ptr + k) % NREQ;
          beats = 0;
        end else if (!(bus.req_ren[owner] || bus.req_wen[owner])) begin
          ptr = (owner + 1) % NREQ;
          owner = -1;
        end else if (bus.ramstate == ACCESS || bus.ramstate == ERROR) begin
          beat_t e;
          e.idx   = owner;
          e.wen   = bus.req_wen[owner];
          e.ren   = bus.req_ren[owner] && !bus.req_wen[owner];
          e.addr  = bus.req_addr[owner*ADDR_W +: ADDR_W];
          e.store = bus.req_store[owner*DATA_W +: DATA_W];
          e.load  = bus.ramload;
          sb.push_back(e);
          beats++;
          if (!(bus.req_lock[owner] && beats < MAX_BURST)) begin
            ptr = (owner + 1) % NREQ;
            owner = -1;
          end
        end
      end
    end
  end

  // Monitor: grant state every cycle, full beat contents on each DUT beat.
  initial begin : monitor
    beat_t e;
    logic [NREQ-1:0] wexp;
    forever begin
      @(negedge CLK); #2;
      if (nRST) begin
        chk("grant_valid", bus.grant_valid, cur_owner >= 0);
        if (cur_owner >= 0) chk("grant_idx", bus.grant_idx, cur_owner);
        else begin
          chk("idle_no_enable", {bus.ramREN, bus.ramWEN}, 2'b00);
          chk("idle_wait", bus.req_wait, {NREQ{1'b1}});
        end
        if (bus.grant_valid && (bus.ramstate == ACCESS || bus.ramstate == ERROR) &&
            bus.req_wait != {NREQ{1'b1}}) begin
          if (sb.size() == 0) begin
            checks++; errors++;
            $display("FAIL beat_unexpected: requester %0d completed a beat, none expected", bus.grant_idx);
          end else begin
            e = sb.pop_front();
            wexp = '1;
            wexp[e.idx] = 1'b0;
            chk("beat_idx", bus.grant_idx, e.idx);
            chk("beat_wen", bus.ramWEN, e.wen);
            chk("beat_ren", bus.ramREN, e.ren);
            chk("beat_addr", bus.ramaddr, e.addr);
            chk("beat_wait", bus.req_wait, wexp);
            if (e.wen) chk("beat_store", bus.ramstore, e.store);
            if (e.ren) chk("beat_load", bus.req_load, e.load);
          end
        end else if (sb.size() != 0) begin
          checks++; errors++;
          $display("FAIL beat_missing: requester %0d expected a beat, got 0 beats", sb[0].idx);
          sb.delete();
        end
      end
    end
  end

  task automatic drv(); @(posedge CLK); #1; endtask
  task automatic smp(); @(negedge CLK); #1; endtask

  task automatic clear_req();
    bus.req_ren   = '0;
    bus.req_wen   = '0;
    bus.req_lock  = '0;
    bus.req_addr  = '0;
    bus.req_store = '0;
    bus.ramstate  = FREE;
  endtask

  task automatic set_addr(input int i, input logic [31:0] a, input logic [31:0] d);
    bus.req_addr[i*ADDR_W +: ADDR_W]  = a;
    bus.req_store[i*DATA_W +: DATA_W] = d;
  endtask

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "timeout");
  end

  initial begin : main
    int left[NREQ];
    int kind[NREQ];
    logic [31:0] ja[NREQ], jd[NREQ];
    logic done_s[NREQ];
    int r, pend;

    clear_req();
    bus.ramload = '0;
    nRST = 1'b0;
    repeat (3) @(posedge CLK);
    smp();
    chk("rst_ren", bus.ramREN, 1'b0);
    chk("rst_wen", bus.ramWEN, 1'b0);
    chk("rst_addr", bus.ramaddr, 32'h0);
    chk("rst_store", bus.ramstore, 32'h0);
    chk("rst_wait", bus.req_wait, 4'hF);
    chk("rst_gvalid", bus.grant_valid, 1'b0);
    chk("rst_gidx", bus.grant_idx, 2'd0);
    chk("rst_err", bus.err_sticky, 1'b0);
    drv(); nRST = 1'b1;

    // Single read with two BUSY cycles, then next pick starts after 1.
    drv(); bus.req_ren[1] = 1'b1; set_addr(1, 32'h40, 32'h0); bus.ramstate = BUSY;
    smp(); chk("rd_latency_idle", bus.ramREN, 1'b0);
    drv();
    smp(); chk("rd_ren", bus.ramREN, 1'b1); chk("rd_addr", bus.ramaddr, 32'h40);
           chk("rd_gidx", bus.grant_idx, 2'd1); chk("rd_busy_wait", bus.req_wait[1], 1'b1);
    drv();
    drv(); bus.ramstate = ACCESS; bus.ramload = 32'hCAFEF00D;
    smp(); chk("rd_wait_drop", bus.req_wait[1], 1'b0); chk("rd_load", bus.req_load, 32'hCAFEF00D);
    drv(); clear_req(); bus.req_ren[0] = 1'b1; bus.req_ren[2] = 1'b1;
           set_addr(0, 32'h100, 0); set_addr(2, 32'h120, 0); bus.ramstate = BUSY;
    smp(); chk("bubble_after_release", bus.grant_valid, 1'b0);
    drv(); bus.ramstate = ACCESS;
    smp(); chk("rr_ptr_after_1", bus.grant_idx, 2'd2);
    drv(); bus.req_ren[2] = 1'b0;
    drv();
    drv(); clear_req();

    // Fairness: everyone requesting, ACCESS every cycle; start pointer is 1.
    drv();
    for (int i = 0; i < NREQ; i++) begin
      bus.req_ren[i] = 1'b1; set_addr(i, 32'h1000 + 32'(i) * 16, 0);
    end
    bus.ramstate = ACCESS;
    for (int k = 0; k < 10; k++) begin
      smp();
      chk("fair_valid", bus.grant_valid, (k % 2) == 1);
      if (k % 2 == 1) chk("fair_idx", bus.grant_idx, (1 + (k - 1) / 2) % NREQ);
      drv();
    end
    clear_req();

    // Locked write burst capped at MAX_BURST, requester 3 next (pointer is 2).
    bus.req_wen[2] = 1'b1; bus.req_lock[2] = 1'b1; set_addr(2, 32'h200, 32'h1111);
    bus.ramstate = ACCESS;
    smp(); chk("burst_idle", bus.grant_valid, 1'b0);
    drv(); bus.req_ren[3] = 1'b1; set_addr(3, 32'h300, 0);
    smp(); chk("burst_b1_idx", bus.grant_idx, 2'd2); chk("burst_b1_wen", bus.ramWEN, 1'b1);
    drv(); set_addr(2, 32'h204, 32'h2222);
    smp(); chk("burst_b2_held", {bus.grant_valid, bus.grant_idx}, 3'b110);
    drv();
    smp(); chk("burst_release", bus.grant_valid, 1'b0);
    drv();
    smp(); chk("burst_next_idx", bus.grant_idx, 2'd3);
    drv(); clear_req();

    // Write wins over read; ERROR beat; abort.
    bus.req_ren[0] = 1'b1; bus.req_wen[0] = 1'b1; set_addr(0, 32'h10, 32'hA5A5A5A5);
    bus.ramstate = BUSY;
    drv();
    smp(); chk("wor_wen", bus.ramWEN, 1'b1); chk("wor_ren", bus.ramREN, 1'b0);
    drv(); bus.ramstate = ERROR;
    smp(); chk("err_wait_drop", bus.req_wait[0], 1'b0);
    drv(); clear_req();
    smp(); chk("err_sticky_set", bus.err_sticky, 1'b1);
    drv(); bus.req_ren[1] = 1'b1; set_addr(1, 32'h50, 0); bus.ramstate = BUSY;
    drv();
    smp(); chk("abort_pre_ren", bus.ramREN, 1'b1);
    drv(); bus.req_ren[1] = 1'b0;
    smp(); chk("abort_no_en", {bus.ramREN, bus.ramWEN}, 2'b00);
    drv();
    smp(); chk("abort_idle", bus.grant_valid, 1'b0); chk("err_sticky_hold", bus.err_sticky, 1'b1);

    // Reset in the middle of a locked burst.
    drv(); bus.req_wen[3] = 1'b1; bus.req_lock[3] = 1'b1; set_addr(3, 32'h700, 32'h77);
    drv();
    smp(); chk("rstmid_pre_wen", bus.ramWEN, 1'b1);
    drv(); nRST = 1'b0;
    #1;
    chk("rstmid_wen", bus.ramWEN, 1'b0);
    chk("rstmid_ren", bus.ramREN, 1'b0);
    chk("rstmid_wait", bus.req_wait, 4'hF);
    chk("rstmid_gidx", bus.grant_idx, 2'd0);
    chk("rstmid_err", bus.err_sticky, 1'b0);
    clear_req();
    drv(); nRST = 1'b1;

    // Randomized traffic: multi-beat jobs, locks, mixed RAM latency.
    for (int i = 0; i < NREQ; i++) begin
      left[i] = 0; kind[i] = 0; ja[i] = '0; jd[i] = '0; done_s[i] = 1'b0;
    end
    for (int c = 0; c < 3000; c++) begin
      drv();
      for (int i = 0; i < NREQ; i++) begin
        if (done_s[i] && left[i] > 0) begin
          left[i]--; ja[i] = ja[i] + 32'd4; jd[i] = $urandom;
        end
        if (left[i] == 0 && c < 2800 && $urandom_range(0, 3) == 0) begin
          left[i] = $urandom_range(1, 3);
          kind[i] = $urandom_range(0, 2);
          ja[i]   = $urandom & 32'hFFFF_FFFC;
          jd[i]   = $urandom;
        end
        bus.req_wen[i]  = (left[i] > 0) && (kind[i] != 0);
        bus.req_ren[i]  = (left[i] > 0) && (kind[i] != 1);
        bus.req_lock[i] = (left[i] > 1);
        set_addr(i, ja[i], jd[i]);
      end
      r = $urandom_range(0, 9);
      bus.ramstate = (r < 3) ? BUSY : (r < 8) ? ACCESS : (r == 8) ? FREE : ERROR;
      bus.ramload  = $urandom;
      smp();
      for (int i = 0; i < NREQ; i++) done_s[i] = !bus.req_wait[i];
    end
    pend = 0;
    for (int i = 0; i < NREQ; i++) pend += left[i];
    chk("random_drained", pend, 0);

    drv(); clear_req();
    repeat (3) @(posedge CLK);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
